// File: rtl/fsic_wbs_dispatch_pkg.sv
// rtl/fsic_wbs_dispatch_pkg.sv - shared definitions for the FSIC Wishbone dispatcher
// FSM encodings, address decode field positions and default error word.
package fsic_wbs_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int BASE_HI = 31;
    localparam int BASE_LO = 16;
    localparam int IDX_HI  = 15;
    localparam int IDX_LO  = 12;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/fsic_wbs_tout_cnt.sv
// rtl/fsic_wbs_tout_cnt.sv - loadable saturating ack-timeout counter
// o_tc flags the last permitted wait cycle; the count never wraps.
module fsic_wbs_tout_cnt #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CW          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc
);

    localparam logic [CW-1:0] MAX_VAL = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] TC_VAL  = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != MAX_VAL)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == TC_VAL);

endmodule

// File: rtl/fsic_wbs_dispatch.sv
// rtl/fsic_wbs_dispatch.sv - Wishbone slave dispatcher with ack timeout for FSIC targets
// Define FSIC_WBS_TOUT_LOG_EN to keep the last timed-out address and a timeout count.
module fsic_wbs_dispatch
    import fsic_wbs_dispatch_pkg::*;
#(
    parameter int          NUM_TGT     = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst,
    input  logic [31:0]             wbs_adr,
    input  logic [31:0]             wbs_wdata,
    input  logic [3:0]              wbs_sel,
    input  logic                    wbs_cyc,
    input  logic                    wbs_stb,
    input  logic                    wbs_we,
    output logic                    wbs_ack,
    output logic [31:0]             wbs_rdata,
    output logic [NUM_TGT-1:0]      tgt_cyc,
    output logic [NUM_TGT-1:0]      tgt_stb,
    output logic                    tgt_we,
    output logic [31:0]             tgt_adr,
    output logic [31:0]             tgt_wdata,
    output logic [3:0]              tgt_sel,
    input  logic [NUM_TGT-1:0]      tgt_ack,
    input  logic [32*NUM_TGT-1:0]   tgt_rdata,
    output logic                    err_pulse,
    output logic [31:0]             tout_adr,
    output logic [7:0]              tout_cnt
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_idx;
    logic          r_we;
    logic [31:0]   r_adr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_sel;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_req;
    logic [3:0]    w_idx;
    logic          w_hit;
    logic [NUM_TGT-1:0] w_onehot;
    logic          w_ack_sel;
    logic [31:0]   w_rd;
    logic          w_tc;
    logic          w_tout_evt;
    logic [CW-1:0] w_cnt;

    assign w_req     = wbs_cyc & wbs_stb;
    assign w_idx     = wbs_adr[IDX_HI:IDX_LO];
    assign w_hit     = (wbs_adr[BASE_HI:BASE_LO] == BASE_ADDR[BASE_HI:BASE_LO])
                       && (32'(w_idx) < 32'(NUM_TGT));
    assign w_onehot  = NUM_TGT'(1) << r_idx;
    assign w_ack_sel = |(tgt_ack & w_onehot);
    assign w_tout_evt = (r_state == ST_ACCESS) && wbs_cyc && !w_ack_sel && w_tc;

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (w_onehot[i]) begin
                w_rd = w_rd | tgt_rdata[32*i +: 32];
            end
        end
    end

    fsic_wbs_tout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CW          (CW)
    ) u_tout_cnt (
        .i_clk      (wb_clk),
        .i_rst      (wb_rst),
        .i_clr      (r_state == ST_IDLE),
        .i_en       (r_state == ST_ACCESS),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_cnt      (w_cnt),
        .o_tc       (w_tc)
    );

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A dropped wbs_cyc abandons the access silently, even if the target acks in that cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_req) w_next = w_hit ? ST_ACCESS : ST_RESP;
            ST_ACCESS: begin
                if (!wbs_cyc)              w_next = ST_IDLE;
                else if (w_ack_sel || w_tc) w_next = ST_RESP;
            end
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wbs_ack   = 1'b0;
        err_pulse = 1'b0;
        tgt_cyc   = '0;
        tgt_stb   = '0;
        case (r_state)
            ST_ACCESS: begin
                tgt_cyc = w_onehot;
                tgt_stb = w_onehot;
            end
            ST_RESP: begin
                wbs_ack   = 1'b1;
                err_pulse = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_req) begin
                    r_idx   <= w_idx;
                    r_we    <= wbs_we;
                    r_adr   <= wbs_adr;
                    r_wdata <= wbs_wdata;
                    r_sel   <= wbs_sel;
                    if (!w_hit) begin
                        r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                    end
                end
                ST_ACCESS: if (wbs_cyc) begin
                    if (w_ack_sel) begin
                        r_rdata <= r_we ? 32'd0 : w_rd;
                        r_err   <= 1'b0;
                    end else if (w_tc) begin
                        r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tgt_we    = r_we;
    assign tgt_adr   = r_adr;
    assign tgt_wdata = r_wdata;
    assign tgt_sel   = r_sel;
    assign wbs_rdata = r_rdata;

`ifdef FSIC_WBS_TOUT_LOG_EN
    logic [31:0] r_tout_adr;
    logic [7:0]  r_tout_cnt;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_tout_adr <= '0;
            r_tout_cnt <= '0;
        end else if (w_tout_evt) begin
            r_tout_adr <= r_adr;
            if (r_tout_cnt != 8'hFF) r_tout_cnt <= r_tout_cnt + 8'd1;
        end
    end

    assign tout_adr = r_tout_adr;
    assign tout_cnt = r_tout_cnt;
`else
    assign tout_adr = 32'd0;
    assign tout_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fsic_wbs_dispatch.sv
// tb/tb_fsic_wbs_dispatch.sv - scoreboard bench for fsic_wbs_dispatch
module tb_fsic_wbs_dispatch;

    logic         wb_clk = 1'b0;
    logic         wb_rst;
    logic [31:0]  wbs_adr;
    logic [31:0]  wbs_wdata;
    logic [3:0]   wbs_sel;
    logic         wbs_cyc;
    logic         wbs_stb;
    logic         wbs_we;
    logic         wbs_ack;
    logic [31:0]  wbs_rdata;
    logic [3:0]   tgt_cyc;
    logic [3:0]   tgt_stb;
    logic         tgt_we;
    logic [31:0]  tgt_adr;
    logic [31:0]  tgt_wdata;
    logic [3:0]   tgt_sel;
    logic [3:0]   tgt_ack;
    logic [127:0] tgt_rdata;
    logic         err_pulse;
    logic [31:0]  tout_adr;
    logic [7:0]   tout_cnt;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    int       rsp_wait [4];
    bit       rsp_en   [4];
    int       rsp_seen [4];
    logic [3:0] spur;

    always #5 wb_clk = ~wb_clk;

    fsic_wbs_dispatch dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .wbs_adr   (wbs_adr),
        .wbs_wdata (wbs_wdata),
        .wbs_sel   (wbs_sel),
        .wbs_cyc   (wbs_cyc),
        .wbs_stb   (wbs_stb),
        .wbs_we    (wbs_we),
        .wbs_ack   (wbs_ack),
        .wbs_rdata (wbs_rdata),
        .tgt_cyc   (tgt_cyc),
        .tgt_stb   (tgt_stb),
        .tgt_we    (tgt_we),
        .tgt_adr   (tgt_adr),
        .tgt_wdata (tgt_wdata),
        .tgt_sel   (tgt_sel),
        .tgt_ack   (tgt_ack),
        .tgt_rdata (tgt_rdata),
        .err_pulse (err_pulse),
        .tout_adr  (tout_adr),
        .tout_cnt  (tout_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Target model: ack in stb cycle rsp_wait[t] (0 = first cycle), plus forced spurious acks.
    initial begin
        logic [3:0] a;
        tgt_ack = '0;
        forever begin
            @(posedge wb_clk);
            #1;
            for (int t = 0; t < 4; t++) begin
                if (tgt_stb[t]) begin
                    a[t] = rsp_en[t] && (rsp_seen[t] == rsp_wait[t]);
                    rsp_seen[t]++;
                end else begin
                    a[t] = 1'b0;
                    rsp_seen[t] = 0;
                end
            end
            tgt_ack = a | spur;
        end
    end

    // Monitor: every ack pops one expected {err, rdata} entry.
    always @(negedge wb_clk) begin
        if (!wb_rst) begin
            if (wbs_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack actual=1 required=0 rdata=%h", wbs_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_rdata", wbs_rdata, mon_e[31:0]);
                    chk("ack_err_pulse", {31'd0, err_pulse}, {31'd0, mon_e[32]});
                end
            end else begin
                chk("err_without_ack", {31'd0, err_pulse}, 32'd0);
            end
        end
    end

    task automatic txn(input string name, input logic [31:0] adr, input logic we,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input int exp_stb_cyc, input logic [3:0] exp_onehot);
        int lat;
        int stbc;
        logic [3:0] seen;
        bit got;
        lat = 0; stbc = 0; seen = '0; got = 0;
        exp_q.push_back({exp_err, exp_rdata});
        @(negedge wb_clk);
        wbs_adr = adr; wbs_we = we; wbs_wdata = wdata; wbs_sel = 4'hF;
        wbs_cyc = 1'b1; wbs_stb = 1'b1;
        @(posedge wb_clk);
        for (int n = 1; n <= 400; n++) begin
            @(negedge wb_clk);
            if (tgt_stb != 4'd0) begin
                stbc++;
                seen = seen | tgt_stb;
            end
            if (wbs_ack) begin
                lat = n;
                got = 1;
                break;
            end
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        if (!got) void'(exp_q.pop_back());
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_stb_cycles"}, stbc, exp_stb_cyc);
        chk({name, "_stb_onehot"}, {28'd0, seen}, {28'd0, exp_onehot});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst = 1'b1;
        wbs_adr = '0; wbs_wdata = '0; wbs_sel = '0; wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
        spur = '0;
        for (int t = 0; t < 4; t++) begin
            rsp_wait[t] = 0; rsp_en[t] = 1; rsp_seen[t] = 0;
        end
        tgt_rdata = {32'h3333_0003, 32'hC0DE_0002, 32'hA5A5_0001, 32'h0000_BAD0};

        repeat (3) @(negedge wb_clk);
        chk("rst_wbs_ack", {31'd0, wbs_ack}, 32'd0);
        chk("rst_wbs_rdata", wbs_rdata, 32'd0);
        chk("rst_tgt_cyc", {28'd0, tgt_cyc}, 32'd0);
        chk("rst_tgt_stb", {28'd0, tgt_stb}, 32'd0);
        chk("rst_tgt_adr", tgt_adr, 32'd0);
        chk("rst_tgt_wdata", tgt_wdata, 32'd0);
        chk("rst_tgt_we_sel", {27'd0, tgt_we, tgt_sel}, 32'd0);
        chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("rst_tout", tout_adr | {24'd0, tout_cnt}, 32'd0);
        wb_rst = 1'b0;

        txn("rd_t1", 32'h3000_1004, 1'b0, 32'd0, 32'hA5A5_0001, 1'b0, 2, 1, 4'b0010);

        rsp_wait[3] = 5;
        txn("wr_t3", 32'h3000_3000, 1'b1, 32'h1234_5678, 32'd0, 1'b0, 7, 6, 4'b1000);
        chk("wr_tgt_wdata", tgt_wdata, 32'h1234_5678);
        chk("wr_tgt_we", {31'd0, tgt_we}, 32'd1);
        chk("wr_tgt_sel", {28'd0, tgt_sel}, 32'hF);

        txn("miss_idx", 32'h3000_5000, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b1, 1, 0, 4'b0000);
        txn("miss_base", 32'h2000_0000, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b1, 1, 0, 4'b0000);

        rsp_en[2] = 0;
        txn("tout_t2", 32'h3000_2008, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b1, 256, 255, 4'b0100);
`ifdef FSIC_WBS_TOUT_LOG_EN
        chk("tout_adr", tout_adr, 32'h3000_2008);
        chk("tout_cnt", {24'd0, tout_cnt}, 32'd1);
`else
        chk("tout_adr_tied", tout_adr, 32'd0);
        chk("tout_cnt_tied", {24'd0, tout_cnt}, 32'd0);
`endif

        rsp_en[2] = 1; rsp_wait[2] = 254;
        txn("ack_at_tc", 32'h3000_200C, 1'b0, 32'd0, 32'hC0DE_0002, 1'b0, 256, 255, 4'b0100);

        spur = 4'b0001; rsp_wait[2] = 3;
        txn("spurious_t0", 32'h3000_2010, 1'b0, 32'd0, 32'hC0DE_0002, 1'b0, 5, 4, 4'b0100);
        spur = 4'b0000;
        repeat (2) @(negedge wb_clk);
        chk("rdata_hold", wbs_rdata, 32'hC0DE_0002);

        rsp_en[1] = 0;
        @(negedge wb_clk);
        wbs_adr = 32'h3000_1000; wbs_we = 0; wbs_cyc = 1; wbs_stb = 1;
        @(posedge wb_clk);
        repeat (3) @(negedge wb_clk);
        chk("abort_stb_before", {28'd0, tgt_stb}, 32'h2);
        wbs_cyc = 0; wbs_stb = 0;
        @(negedge wb_clk);
        chk("abort_stb_after", {28'd0, tgt_stb}, 32'd0);
        chk("abort_cyc_after", {28'd0, tgt_cyc}, 32'd0);
        repeat (5) @(negedge wb_clk);
        chk("abort_no_ack", exp_q.size(), 32'd0);

        rsp_en[2] = 0;
        @(negedge wb_clk);
        wbs_adr = 32'h3000_2000; wbs_cyc = 1; wbs_stb = 1;
        @(posedge wb_clk);
        repeat (3) @(negedge wb_clk);
        chk("rstmid_cyc_before", {28'd0, tgt_cyc}, 32'h4);
        wb_rst = 1'b1;
        #1;
        chk("rstmid_strobes", {24'd0, tgt_cyc, tgt_stb}, 32'd0);
        chk("rstmid_ack", {31'd0, wbs_ack}, 32'd0);
        chk("rstmid_rdata", wbs_rdata, 32'd0);
        chk("rstmid_tgt_adr", tgt_adr, 32'd0);
        chk("rstmid_err", {31'd0, err_pulse}, 32'd0);
        wbs_cyc = 0; wbs_stb = 0;
        @(negedge wb_clk);
        wb_rst = 1'b0;

        rsp_en[1] = 1; rsp_wait[1] = 0;
        txn("post_rst", 32'h3000_1004, 1'b0, 32'd0, 32'hA5A5_0001, 1'b0, 2, 1, 4'b0010);

        repeat (3) @(negedge wb_clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
